// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit signed shift-add multiplier datapath:
// default operand width, shift count per multiply and the command encoding
// produced by the datapath's priority encoder.
package mult_pkg;

   localparam int MULT_WIDTH     = 8;
   localparam int SHIFTS_PER_MUL = 8;

   // One decoded command per cycle, highest-priority strobe wins.
   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_CLRLD = 3'd1,
      CMD_CLRA  = 3'd2,
      CMD_SUB   = 3'd3,
      CMD_ADD   = 3'd4,
      CMD_SHIFT = 3'd5
   } cmd_t;

endpackage : mult_pkg

// File: rtl/adder9.sv
// Ripple-carry adder built from full adders. Width N defaults to 9
// (operand width plus one sign-extension bit). The carry out of the top
// bit is never formed: the datapath discards it.
module adder9 #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum
);

   logic [N-1:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum[i] = a[i] ^ b[i] ^ w_c[i];
      if (i < N - 1) begin : g_carry
         assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
      end
   end

endmodule : adder9

// File: rtl/mult_datapath.sv
// Register/arithmetic datapath of the 8-bit signed shift-add multiplier.
// Holds X (sign extension), A (accumulator) and B (multiplier); after a full
// run {A,B} is the two's-complement product. S is synchronised with two flops.
// Optional feature macro: MULT_DATAPATH_SHIFT_CNT_EN adds a saturating shift
// counter driving Done; when undefined Done is tied low.
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] S,
   input  logic             Clr_Ld,
   input  logic             clearA,
   input  logic             Add,
   input  logic             Sub,
   input  logic             Shift,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             M,
   output logic             Done
);

   logic [WIDTH-1:0] r_s_q1;
   logic [WIDTH-1:0] r_s_s;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_x;

   cmd_t             w_cmd;
   logic [WIDTH:0]   w_a_ext;
   logic [WIDTH:0]   w_s_ext;
   logic [WIDTH:0]   w_op_b;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;

   // Two-flop synchroniser for the asynchronous switch operand.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_s_q1 <= {WIDTH{1'b0}};
         r_s_s  <= {WIDTH{1'b0}};
      end else begin
         r_s_q1 <= S;
         r_s_s  <= r_s_q1;
      end
   end

   // Priority encoder: Clr_Ld > clearA > Sub > Add > Shift.
   always_comb begin
      w_cmd = CMD_NONE;
      if (Clr_Ld) begin
         w_cmd = CMD_CLRLD;
      end else if (clearA) begin
         w_cmd = CMD_CLRA;
      end else if (Sub) begin
         w_cmd = CMD_SUB;
      end else if (Add) begin
         w_cmd = CMD_ADD;
      end else if (Shift) begin
         w_cmd = CMD_SHIFT;
      end else begin
         w_cmd = CMD_NONE;
      end
   end

   // One shared adder: subtraction inverts the operand and forces carry-in.
   assign w_a_ext = {r_a[WIDTH-1], r_a};
   assign w_s_ext = {r_s_s[WIDTH-1], r_s_s};
   assign w_cin   = (w_cmd == CMD_SUB);
   assign w_op_b  = w_cin ? ~w_s_ext : w_s_ext;

   adder9 #(
      .N(WIDTH + 1)
   ) u_adder (
      .a  (w_a_ext),
      .b  (w_op_b),
      .cin(w_cin),
      .sum(w_sum)
   );

   // X/A/B register update for the decoded command.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_x <= 1'b0;
         r_a <= {WIDTH{1'b0}};
         r_b <= {WIDTH{1'b0}};
      end else begin
         case (w_cmd)
            CMD_CLRLD: begin
               r_x <= 1'b0;
               r_a <= {WIDTH{1'b0}};
               r_b <= r_s_s;
            end
            CMD_CLRA: begin
               r_x <= 1'b0;
               r_a <= {WIDTH{1'b0}};
            end
            CMD_SUB, CMD_ADD: begin
               r_x <= w_sum[WIDTH];
               r_a <= w_sum[WIDTH-1:0];
            end
            CMD_SHIFT: begin
               r_a <= {r_x, r_a[WIDTH-1:1]};
               r_b <= {r_a[0], r_b[WIDTH-1:1]};
            end
            default: begin
               r_x <= r_x;
               r_a <= r_a;
               r_b <= r_b;
            end
         endcase
      end
   end

`ifdef MULT_DATAPATH_SHIFT_CNT_EN
   localparam logic [3:0] C_SHIFTS = 4'(SHIFTS_PER_MUL);

   logic [3:0] r_cnt;

   // Saturating count of executed shifts, cleared with each new operand set.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_cnt <= 4'd0;
      end else begin
         case (w_cmd)
            CMD_CLRLD, CMD_CLRA: begin
               r_cnt <= 4'd0;
            end
            CMD_SHIFT: begin
               if (r_cnt != C_SHIFTS) begin
                  r_cnt <= r_cnt + 4'd1;
               end else begin
                  r_cnt <= r_cnt;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign Done = (r_cnt == C_SHIFTS);
`else
   assign Done = 1'b0;
`endif

   assign Aval = r_a;
   assign Bval = r_b;
   assign X    = r_x;
   assign M    = r_b[0];

endmodule : mult_datapath

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed steps plus random signed
// multiplies, checked against a behavioural model using plain signed arithmetic.
module tb_mult_datapath;
   import mult_pkg::*;

   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic [W-1:0] S = 8'h00;
   logic         Clr_Ld = 1'b0;
   logic         clearA = 1'b0;
   logic         Add = 1'b0;
   logic         Sub = 1'b0;
   logic         Shift = 1'b0;
   logic [W-1:0] Aval;
   logic [W-1:0] Bval;
   logic         X;
   logic         M;
   logic         Done;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [W-1:0] m_a, m_b, m_p1, m_p2;
   logic         m_x;
   int           m_cnt;

   always #5 Clk = ~Clk;

   mult_datapath #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .S(S), .Clr_Ld(Clr_Ld), .clearA(clearA),
      .Add(Add), .Sub(Sub), .Shift(Shift), .Aval(Aval), .Bval(Bval),
      .X(X), .M(M), .Done(Done)
   );

   // Behavioural effect of one clock edge with the given strobes.
   task automatic model_edge(input logic rst, clr, ca, ad, sb, sh);
      int r;
      logic signed [16:0] v;
      if (rst) begin
         m_x = 1'b0; m_a = 8'h00; m_b = 8'h00; m_p1 = 8'h00; m_p2 = 8'h00; m_cnt = 0;
      end else begin
         if (clr) begin
            m_b = m_p2; m_a = 8'h00; m_x = 1'b0; m_cnt = 0;
         end else if (ca) begin
            m_a = 8'h00; m_x = 1'b0; m_cnt = 0;
         end else if (sb || ad) begin
            if (sb) r = $signed(m_a) - $signed(m_p2);
            else    r = $signed(m_a) + $signed(m_p2);
            m_x = r[8];
            m_a = r[7:0];
         end else if (sh) begin
            v = {m_x, m_a, m_b};
            v = v >>> 1;
            {m_x, m_a, m_b} = v;
            if (m_cnt < SHIFTS_PER_MUL) m_cnt = m_cnt + 1;
         end
         m_p2 = m_p1;
         m_p1 = S;
      end
   endtask

   task automatic step(input logic rst, clr, ca, ad, sb, sh);
      Reset = rst; Clr_Ld = clr; clearA = ca; Add = ad; Sub = sb; Shift = sh;
      @(posedge Clk);
      model_edge(rst, clr, ca, ad, sb, sh);
      #1;
      Reset = 1'b0; Clr_Ld = 1'b0; clearA = 1'b0; Add = 1'b0; Sub = 1'b0; Shift = 1'b0;
   endtask

   task automatic check(input string tag);
      logic exp_done;
`ifdef MULT_DATAPATH_SHIFT_CNT_EN
      exp_done = (m_cnt == SHIFTS_PER_MUL);
`else
      exp_done = 1'b0;
`endif
      n_assert++;
      assert (Aval === m_a) else begin n_fail++; $error("FAIL %s Aval observed=%h expected=%h", tag, Aval, m_a); end
      n_assert++;
      assert (Bval === m_b) else begin n_fail++; $error("FAIL %s Bval observed=%h expected=%h", tag, Bval, m_b); end
      n_assert++;
      assert (X === m_x) else begin n_fail++; $error("FAIL %s X observed=%b expected=%b", tag, X, m_x); end
      n_assert++;
      assert (M === m_b[0]) else begin n_fail++; $error("FAIL %s M observed=%b expected=%b", tag, M, m_b[0]); end
      n_assert++;
      assert (Done === exp_done) else begin n_fail++; $error("FAIL %s Done observed=%b expected=%b", tag, Done, exp_done); end
   endtask

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin n_fail++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp); end
   endtask

   task automatic set_s(input logic [W-1:0] v);
      S = v;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic load_b(input logic [W-1:0] v);
      set_s(v);
      step(0, 1, 0, 0, 0, 0);
      check("load");
   endtask

   // Control-unit style run: n (Add|Sub, Shift) iterations driven by M.
   task automatic run(input int n, input logic both_last);
      for (int i = 0; i < n; i++) begin
         if (M) begin
            if (i == SHIFTS_PER_MUL - 1) step(0, 0, 0, both_last, 1'b1, 0);
            else                         step(0, 0, 0, 1'b1, 0, 0);
            check("run_arith");
         end
         step(0, 0, 0, 0, 0, 1);
         check("run_shift");
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           p;
      logic [15:0]  ep;

      // reset then idle
      m_a = 8'h00; m_b = 8'h00; m_x = 1'b0; m_p1 = 8'h00; m_p2 = 8'h00; m_cnt = 0;
      S = 8'hA5;
      step(1, 0, 0, 0, 0, 0);
      check("reset");
      check_val("reset_AB", {Aval, Bval}, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0);
         check("idle");
      end

      // 7 * 59 = 413
      load_b(8'h07);
      check_val("load7_M", {15'd0, M}, 16'h0001);
      set_s(8'h3B);
      run(SHIFTS_PER_MUL, 1'b0);
      check_val("prod_7x59", {Aval, Bval}, 16'h019D);

      // -7 * 59 with Add and Sub together on the last step
      load_b(8'hF9);
      set_s(8'h3B);
      run(SHIFTS_PER_MUL, 1'b1);
      check_val("prod_m7x59", {Aval, Bval}, 16'hFE63);

      // -7 * -59
      load_b(8'hF9);
      set_s(8'hC5);
      run(SHIFTS_PER_MUL, 1'b0);
      check_val("prod_m7xm59", {Aval, Bval}, 16'h019D);

      // overflow into X boundary: 0x7F + 0x01
      load_b(8'h00);
      set_s(8'h7F);
      step(0, 0, 0, 1, 0, 0);
      check("add_7f");
      set_s(8'h01);
      step(0, 0, 0, 1, 0, 0);
      check("add_7f_plus1");
      check_val("ovf_A", {7'd0, X, Aval}, 16'h0080);
      step(0, 0, 0, 0, 0, 1);
      check("shift_after_ovf");
      check_val("ovf_shift_A", {7'd0, X, Aval}, 16'h0040);

      // Add with Shift together: shift dropped
      step(0, 0, 0, 1, 0, 1);
      check("add_and_shift");

      // S latency: Add one edge after S changes still uses the old value
      S = 8'h10;
      step(0, 0, 0, 1, 0, 0);
      check("sync_lat1");
      step(0, 0, 0, 1, 0, 0);
      check("sync_lat2");

      // reset mid-run after 3 shifts
      load_b(8'h07);
      set_s(8'h3B);
      run(3, 1'b0);
      step(1, 0, 0, 0, 0, 0);
      check("mid_reset");
      check_val("mid_reset_AB", {Aval, Bval}, 16'h0000);

      // clearA mid-run after 3 shifts
      load_b(8'h07);
      set_s(8'h3B);
      run(3, 1'b0);
      step(0, 0, 1, 0, 0, 0);
      check("mid_clearA");
      check_val("mid_clearA_A", {7'd0, X, Aval}, 16'h0000);

      // Clr_Ld mid-run acts as fresh load
      set_s(8'h5A);
      step(0, 1, 0, 0, 0, 0);
      check("mid_clrld");

      // random signed multiplies
      for (int k = 0; k < 8; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         load_b(rb);
         set_s(ra);
         run(SHIFTS_PER_MUL, 1'($urandom_range(0, 1)));
         p  = $signed(ra) * $signed(rb);
         ep = p[15:0];
         check_val("rand_prod", {Aval, Bval}, ep);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_mult_datapath

// File: doc/mult_datapath.md
# mult_datapath

- Register/arithmetic datapath for the 8-bit signed shift-add multiplier.
- Sits directly downstream of the multiplier control unit. It consumes that unit's one-hot-ish command strobes (Clr_Ld, clearA, Add, Sub, Shift) and returns M, the current multiplier LSB.
- Holds the sign-extension bit X, the accumulator A and the multiplier B. After a full run, {A,B} holds the 16-bit two's-complement product.
- Switch operand S is synchronised internally. The block also feeds A/B to the hex display drivers.

## Interface

Parameters:
- WIDTH, 8: operand width. A, B and S are WIDTH bits; the adder is WIDTH+1 bits.

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- S  input  WIDTH  switch operand, asynchronous to Clk
- Clr_Ld  input  1  load B from S, clear X and A
- clearA  input  1  clear X and A, keep B
- Add  input  1  {X,A} <= A + S (signed)
- Sub  input  1  {X,A} <= A - S (signed)
- Shift  input  1  arithmetic right shift of {X,A,B}
- Aval  output  WIDTH  A register
- Bval  output  WIDTH  B register
- X  output  1  sign-extension bit
- M  output  1  B[0], returned to the control unit
- Done  output  1  eight shifts completed (see Configuration)

## Operation

- S passes through a two-flop synchroniser (S_q1 -> S_s). All arithmetic and loads use S_s.
- Command priority per cycle: Reset > Clr_Ld > clearA > Sub > Add > Shift. Only the highest-priority asserted command executes.
  - Sub outranks Add because the control unit raises both in its final-cycle subtract state.
- Reset: X=0, A=0, B=0, synchroniser flops=0, shift count=0.
- Clr_Ld: B<=S_s; A<=0; X<=0; count<=0.
- clearA: A<=0; X<=0; count<=0; B unchanged.
- Add: the 9-bit sum {A[7],A} + {S_s[7],S_s} gives {X,A}. Carry out of bit 8 is discarded.
- Sub: {A[7],A} + ~{S_s[7],S_s} + 1 gives {X,A}. This uses the same adder, with operand inversion and carry-in=1.
- Shift: A<={X,A[7:1]}; B<={A[0],B[7:1]}; X holds.
- No command asserted: all registers hold.
- M = B[0], combinational from the register, so it is valid in the same cycle the control unit samples it.
- Add or Sub together with Shift in one cycle is not produced by the control unit. If it occurs, the arithmetic executes and Shift is dropped.

## Timing

- Output reset values: Aval=0, Bval=0, X=0, M=0, Done=0. All are valid the cycle after Reset is sampled high.
- Command latency: 1 cycle. A strobe sampled high at edge n is reflected on Aval/Bval/X/M after edge n.
- S latency: a change on S reaches S_s after 2 edges. S must be stable for 2 cycles before Run.
- A full multiply is 8 (Add|Sub, Shift) pairs plus the clear cycle, all driven by the control unit. The block has no internal sequencing beyond the shift counter.
- Reset mid-multiply: everything clears on that edge. The partial product is lost.
- Clr_Ld mid-multiply: B reloads and A/X clear, the same as a fresh load.

## Configuration

- Macro: MULT_DATAPATH_SHIFT_CNT_EN.
- Defined:
  - A 4-bit shift counter increments on each executed Shift and saturates at 8.
  - It is cleared by Reset, Clr_Ld and clearA.
  - Done=1 while count==8. This lets the bench and display confirm completion independently of the control FSM.
- Undefined: no counter flops; Done is tied to 0.

## Structure

- Shared package mult_pkg holds:
  - WIDTH default
  - the cmd_t enum (CMD_NONE, CMD_CLRLD, CMD_CLRA, CMD_SUB, CMD_ADD, CMD_SHIFT) produced by the priority encoder
  - the SHIFTS_PER_MUL=8 constant
- Sub-module adder9: (WIDTH+1)-bit ripple adder built from full adders. Ports are a, b, cin, sum. It is instantiated once; Sub drives operand inversion and cin.
- The top level contains the synchroniser, the command priority encoder, the register update and the optional counter.

## Test plan

- Reset then idle, S=0xA5 -> Aval=0x00, Bval=0x00, X=0, M=0, Done=0. No change until a command arrives.
- S=0x07, wait 2 cycles, Clr_Ld pulse -> Bval=0x07, Aval=0x00, M=1. Then S=0x3B and a full control-unit run -> {Aval,Bval}=0x019D (413), X=0, Done=1.
- B=0xF9 (-7), S=0x3B; full run, with the final step raising Add and Sub together -> Sub executes, {Aval,Bval}=0xFE63 (-413).
- B=0xF9, S=0xC5 (-59), full run -> {Aval,Bval}=0x019D.
- A=0x7F, S=0x01, Add -> X=0, Aval=0x80. Then Shift -> Aval=0x40, X=0.
- Mid-run after 3 shifts: assert Reset -> all outputs 0 the next cycle. Separately, a clearA pulse -> A and X clear, B keeps its shifted value, Done=0.
